// File: rtl/lpc_reg_pkg.sv
// Shared types and constants for the LPC register bank.
// The LPC_REG_WRLOCK_EN macro enables the key-sequence write lock.
package lpc_reg_pkg;

  localparam int DefNumRegs = 32;
  localparam int MaxBits    = 2048;

  localparam logic [7:0] KeyLock    = 8'hA5;
  localparam logic [7:0] KeyUnlock1 = 8'h55;
  localparam logic [7:0] KeyUnlock2 = 8'hAA;

`ifdef LPC_REG_WRLOCK_EN
  localparam bit WrLockEn = 1'b1;
`else
  localparam bit WrLockEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    LockUnlocked = 2'd0,
    LockLocked   = 2'd1,
    LockKey1     = 2'd2
  } lockState_t;

  function automatic logic [7:0] sliceByte(input logic [MaxBits-1:0] vec, input int idx);
    return vec[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/lpc_reg_bank_if.sv
// Register-access bus between the LPC I/O cycle decoder (master) and the bank (slave).
interface lpc_reg_bank_if;
  logic [7:0] Addr;
  logic       Wr;
  logic       Rd;
  logic [7:0] DataWrSW;
  logic [7:0] DataRd;

  modport master (output Addr, Wr, Rd, DataWrSW, input DataRd);
  modport slave  (input Addr, Wr, Rd, DataWrSW, output DataRd);
endinterface

// File: rtl/lpc_reg_lock.sv
// Key-sequence write-lock FSM: A5 locks; 55 then AA on consecutive writes unlocks.
module lpc_reg_lock
  import lpc_reg_pkg::*;
(
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       Wr,
  input  logic       AddrHit,
  input  logic [7:0] DataWrSW,
  output logic       Locked
);

  lockState_t state, nextState;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) state <= LockUnlocked;
    else           state <= nextState;
  end

  // NOTE: nextState gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nextState = state;
    if (Wr) begin
      unique case (state)
        LockUnlocked: if (AddrHit && DataWrSW == KeyLock)    nextState = LockLocked;
        LockLocked:   if (AddrHit && DataWrSW == KeyUnlock1) nextState = LockKey1;
        LockKey1:     nextState = (AddrHit && DataWrSW == KeyUnlock2) ? LockUnlocked : LockLocked;
        default:      nextState = LockLocked;
      endcase
    end
  end

  assign Locked = (state != LockUnlocked);

endmodule

// File: rtl/lpc_reg_bank.sv
// Parametrised LPC byte-register bank with per-bit attributes, registered read and sticky IRQ.
// Optional write lock compiled in with LPC_REG_WRLOCK_EN.
module lpc_reg_bank
  import lpc_reg_pkg::*;
#(
  parameter int                    NUM_REGS    = DefNumRegs,
  parameter logic [NUM_REGS*8-1:0] RESET_VAL   = '0,
  parameter logic [NUM_REGS*8-1:0] WR_MASK     = '1,
  parameter logic [NUM_REGS*8-1:0] HW_MASK     = '0,
  parameter logic [NUM_REGS*8-1:0] STICKY_MASK = '0,
  parameter logic [NUM_REGS*8-1:0] RC_MASK     = '0,
  parameter logic [NUM_REGS*8-1:0] LOCK_MASK   = '0,
  parameter logic [NUM_REGS*8-1:0] IRQ_MASK    = '0,
  parameter int                    LOCK_REG    = 31
) (
  input  logic                  LpcClock,
  input  logic                  PciReset,
  lpc_reg_bank_if.slave         bus,
  input  logic [NUM_REGS*8-1:0] HwVal,
  input  logic [NUM_REGS*8-1:0] HwSet,
  output logic [NUM_REGS*8-1:0] DataReg,
  output logic                  IrqOut,
  output logic                  Locked
);

  localparam int W = NUM_REGS * 8;

  logic [W-1:0]        regQ, regD;
  logic [7:0]          rdQ, rdD;
  logic                irqQ;
  logic                lockedNow;
  logic                rdOnly;
  logic [NUM_REGS-1:0] hit;
  logic [7:0]          hwM, stM, rcM, lkM, wrM, swEn, clrM, cur, nxt;

`ifdef LPC_REG_WRLOCK_EN
  lpc_reg_lock uLock (
    .LpcClock (LpcClock),
    .PciReset (PciReset),
    .Wr       (bus.Wr),
    .AddrHit  (bus.Addr == 8'(LOCK_REG)),
    .DataWrSW (bus.DataWrSW),
    .Locked   (lockedNow)
  );
`else
  assign lockedNow = 1'b0;
`endif

  // A simultaneous Wr and Rd is a write: no read data update, no read-clear.
  assign rdOnly = bus.Rd && !bus.Wr;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGS; i++) hit[i] = (bus.Addr == 8'(i));
  end

  always_comb begin
    regD = regQ;
    rdD  = rdOnly ? 8'h00 : rdQ;
    hwM = '0; stM = '0; rcM = '0; lkM = '0; wrM = '0;
    swEn = '0; clrM = '0; cur = '0; nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hwM  = sliceByte(MaxBits'(HW_MASK), i);
      stM  = sliceByte(MaxBits'(STICKY_MASK), i) & ~hwM;
      rcM  = sliceByte(MaxBits'(RC_MASK), i) & stM;
      lkM  = lockedNow ? sliceByte(MaxBits'(LOCK_MASK), i) : 8'h00;
      wrM  = sliceByte(MaxBits'(WR_MASK), i) & ~hwM & ~stM;
      swEn = (bus.Wr && hit[i] && !(WrLockEn && i == LOCK_REG)) ? ~lkM : 8'h00;
      clrM = (swEn & bus.DataWrSW & stM) | ((rdOnly && hit[i]) ? rcM : 8'h00);
      cur  = regQ[i*8 +: 8];
      // Apply lowest priority first so later terms override: write, clear, set, HW.
      nxt  = (cur & ~(wrM & swEn)) | (bus.DataWrSW & wrM & swEn);
      nxt  = (nxt & ~clrM) | (HwSet[i*8 +: 8] & stM);
      nxt  = (nxt & ~hwM) | (HwVal[i*8 +: 8] & hwM);
      regD[i*8 +: 8] = nxt;
      if (rdOnly && hit[i]) rdD = (WrLockEn && i == LOCK_REG) ? {7'b0, lockedNow} : cur;
    end
  end

  // NOTE: the bank is flops, not RAM, so every byte resets to its RESET_VAL.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      regQ <= RESET_VAL;
      rdQ  <= 8'h00;
      irqQ <= 1'b0;
    end else begin
      regQ <= regD;
      rdQ  <= rdD;
      irqQ <= |(regQ & IRQ_MASK & STICKY_MASK);
    end
  end

  assign DataReg    = regQ;
  assign bus.DataRd = rdQ;
  assign IrqOut     = irqQ;
  assign Locked     = lockedNow;

endmodule
